streaming_pooling_unit: RTL and testbench

Sequential, streaming successor to the combinational pooling stage. It sits between the convolution engine and the flatten/dense stage of the CNN. It accepts convolution output elements one per handshake in feature-major raster order and produces pooled elements in the same order. Per-frame selectable max or average pooling, signed or unsigned data, and partial edge tiles are supported, with a single line of partial-result storage in place of the full feature-map array.

---
 rtl/streaming_pooling_unit.sv | 218 +++++++++++++++++++++
 tb/tb_streaming_pooling_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/streaming_pooling_unit.sv
`default_nettype none
// ============================================================================
// Module      : streaming_pooling_unit
// Description : Streaming max/average pooling over feature-major raster input.
//               A single line of partial tile results is kept, indexed by the
//               tile column. One input per cycle, single-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module streaming_pooling_unit #(
    parameter int NUM_FEATURES       = 10,
    parameter int CONVOLUTION_HEIGHT = 10,
    parameter int CONVOLUTION_WIDTH  = 10,
    parameter int POOLING_STRIDE     = 2,
    parameter int DATA_WIDTH         = 8,
    parameter int SIGNED_DATA        = 0,
    localparam int POOLED_HEIGHT = (CONVOLUTION_HEIGHT + POOLING_STRIDE - 1) / POOLING_STRIDE,
    localparam int POOLED_WIDTH  = (CONVOLUTION_WIDTH + POOLING_STRIDE - 1) / POOLING_STRIDE,
    localparam int FEAT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
    localparam int PROW_W = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1,
    localparam int PCOL_W = (POOLED_WIDTH > 1) ? $clog2(POOLED_WIDTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pool_start,
    input  logic                  pool_mode,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [FEAT_W-1:0]     out_feature,
    output logic [PROW_W-1:0]     out_row,
    output logic [PCOL_W-1:0]     out_col,
    output logic                  done
);

    localparam int c_row_w   = (CONVOLUTION_HEIGHT > 1) ? $clog2(CONVOLUTION_HEIGHT) : 1;
    localparam int c_col_w   = (CONVOLUTION_WIDTH > 1) ? $clog2(CONVOLUTION_WIDTH) : 1;
    localparam int c_sub_w   = (POOLING_STRIDE > 1) ? $clog2(POOLING_STRIDE) : 1;
    localparam int c_acc_w   = DATA_WIDTH + 2 * $clog2(POOLING_STRIDE) + 1;
    // In-bounds extent of the last (possibly partial) tile row/column
    localparam int c_last_rows = CONVOLUTION_HEIGHT - (POOLED_HEIGHT - 1) * POOLING_STRIDE;
    localparam int c_last_cols = CONVOLUTION_WIDTH - (POOLED_WIDTH - 1) * POOLING_STRIDE;

    localparam logic [FEAT_W-1:0]  c_last_feat = FEAT_W'(NUM_FEATURES - 1);
    localparam logic [c_row_w-1:0] c_last_row  = c_row_w'(CONVOLUTION_HEIGHT - 1);
    localparam logic [c_col_w-1:0] c_last_col  = c_col_w'(CONVOLUTION_WIDTH - 1);
    localparam logic [c_sub_w-1:0] c_sub_last  = c_sub_w'(POOLING_STRIDE - 1);
    localparam logic [PROW_W-1:0]  c_last_prow = PROW_W'(POOLED_HEIGHT - 1);
    localparam logic [PCOL_W-1:0]  c_last_pcol = PCOL_W'(POOLED_WIDTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_accum = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_mode;
    logic [FEAT_W-1:0]     r_feature;
    logic [c_row_w-1:0]    r_row;
    logic [c_col_w-1:0]    r_col;
    logic [c_sub_w-1:0]    r_row_sub;
    logic [c_sub_w-1:0]    r_col_sub;
    logic [PROW_W-1:0]     r_tile_row;
    logic [PCOL_W-1:0]     r_tile_col;
    logic [c_acc_w-1:0]    r_acc [POOLED_WIDTH];
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [FEAT_W-1:0]     r_out_feature;
    logic [PROW_W-1:0]     r_out_row;
    logic [PCOL_W-1:0]     r_out_col;
    logic                  r_done;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_frame_end;
    logic                  w_sign;
    logic [c_acc_w-1:0]    w_in_ext;
    logic [c_acc_w-1:0]    w_old;
    logic                  w_first;
    logic                  w_gt;
    logic [c_acc_w-1:0]    w_combined;
    logic                  w_tile_done;
    logic [c_acc_w-1:0]    w_rows_in;
    logic [c_acc_w-1:0]    w_cols_in;
    logic [c_acc_w-1:0]    w_count;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_start     = (r_state == c_idle) && pool_start;
    assign w_in_ready  = (r_state == c_accum) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_frame_end = (r_feature == c_last_feat) && (r_row == c_last_row) && (r_col == c_last_col);

    // Unsigned data is zero-extended, so a signed compare is correct in both modes
    assign w_sign     = (SIGNED_DATA != 0) && in_data[DATA_WIDTH-1];
    assign w_in_ext   = {{(c_acc_w - DATA_WIDTH){w_sign}}, in_data};
    assign w_old      = r_acc[r_tile_col];
    assign w_first    = (r_row_sub == '0) && (r_col_sub == '0);
    assign w_gt       = $signed(w_in_ext) > $signed(w_old);
    assign w_combined = w_first ? w_in_ext :
                        r_mode  ? (w_old + w_in_ext) :
                        (w_gt ? w_in_ext : w_old);

    assign w_tile_done = ((r_row_sub == c_sub_last) || (r_row == c_last_row)) &&
                         ((r_col_sub == c_sub_last) || (r_col == c_last_col));

    // True element count of the current tile, smaller on the bottom/right edges
    assign w_rows_in = (r_tile_row == c_last_prow) ? c_acc_w'(c_last_rows) : c_acc_w'(POOLING_STRIDE);
    assign w_cols_in = (r_tile_col == c_last_pcol) ? c_acc_w'(c_last_cols) : c_acc_w'(POOLING_STRIDE);
    assign w_count   = w_rows_in * w_cols_in;
    // Signed division truncates toward zero; the quotient always fits DATA_WIDTH
    assign w_result  = r_mode ? DATA_WIDTH'($signed(w_combined) / $signed(w_count))
                              : w_combined[DATA_WIDTH-1:0];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= c_idle;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (pool_start) w_next_state = c_accum;
            c_accum: if (w_accept && w_frame_end) w_next_state = c_drain;
            c_drain: if (!r_out_valid || out_ready) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Output decode
    always_comb begin
        busy        = (r_state != c_idle);
        in_ready    = w_in_ready;
        out_valid   = r_out_valid;
        out_data    = r_out_data;
        out_feature = r_out_feature;
        out_row     = r_out_row;
        out_col     = r_out_col;
        done        = r_done;
    end

    // Raster position counters and mode latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= 1'b0; r_feature <= '0; r_row <= '0; r_col <= '0;
            r_row_sub <= '0; r_col_sub <= '0; r_tile_row <= '0; r_tile_col <= '0;
        end else if (w_start) begin
            r_mode <= pool_mode; r_feature <= '0; r_row <= '0; r_col <= '0;
            r_row_sub <= '0; r_col_sub <= '0; r_tile_row <= '0; r_tile_col <= '0;
        end else if (w_accept) begin
            if (r_col == c_last_col) begin
                r_col      <= '0;
                r_col_sub  <= '0;
                r_tile_col <= '0;
                if (r_row == c_last_row) begin
                    r_row      <= '0;
                    r_row_sub  <= '0;
                    r_tile_row <= '0;
                    r_feature  <= (r_feature == c_last_feat) ? '0 : r_feature + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                    if (r_row_sub == c_sub_last) begin
                        r_row_sub  <= '0;
                        r_tile_row <= r_tile_row + 1'b1;
                    end else begin
                        r_row_sub <= r_row_sub + 1'b1;
                    end
                end
            end else begin
                r_col <= r_col + 1'b1;
                if (r_col_sub == c_sub_last) begin
                    r_col_sub  <= '0;
                    r_tile_col <= r_tile_col + 1'b1;
                end else begin
                    r_col_sub <= r_col_sub + 1'b1;
                end
            end
        end
    end

    // Partial tile results, one entry per tile column
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < POOLED_WIDTH; i++) r_acc[i] <= '0;
        end else if (w_accept) begin
            r_acc[r_tile_col] <= w_combined;
        end
    end

    // Single-entry output register; loads on tile completion, clears on handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0; r_out_data <= '0;
            r_out_feature <= '0; r_out_row <= '0; r_out_col <= '0;
        end else if (w_accept && w_tile_done) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_result;
            r_out_feature <= r_feature;
            r_out_row     <= r_tile_row;
            r_out_col     <= r_tile_col;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Frame completion pulse, coincident with the return to idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_done <= 1'b0;
        else          r_done <= (r_state == c_drain) && (!r_out_valid || out_ready);
    end

endmodule
`default_nettype wire

// File: tb/tb_streaming_pooling_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_streaming_pooling_unit
// Description : Self-checking bench: a signed 2x5x5 instance driven with random
//               frames against a tile-level reference model, and an unsigned
//               1x4x4 instance with fixed known-answer frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_streaming_pooling_unit;

    localparam int NF = 2, H = 5, W = 5, S = 2, DW = 8;
    localparam int PH = 3, PW = 3, N = NF * H * W;

    typedef struct {
        int data;
        int f;
        int r;
        int c;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n = 1'b0;
    logic       pool_start = 1'b0, pool_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic       busy, in_ready, out_valid, done;
    logic [7:0] out_data;
    logic [0:0] out_feature;
    logic [1:0] out_row, out_col;

    logic       b_pool_start = 1'b0, b_pool_mode = 1'b0, b_in_valid = 1'b0;
    logic [7:0] b_in_data = '0;
    logic       b_busy, b_in_ready, b_out_valid, b_done;
    logic [7:0] b_out_data;
    logic [0:0] b_out_feature, b_out_row, b_out_col;

    streaming_pooling_unit #(
        .NUM_FEATURES(NF), .CONVOLUTION_HEIGHT(H), .CONVOLUTION_WIDTH(W),
        .POOLING_STRIDE(S), .DATA_WIDTH(DW), .SIGNED_DATA(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pool_start(pool_start), .pool_mode(pool_mode),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_feature(out_feature), .out_row(out_row), .out_col(out_col), .done(done)
    );

    streaming_pooling_unit #(
        .NUM_FEATURES(1), .CONVOLUTION_HEIGHT(4), .CONVOLUTION_WIDTH(4),
        .POOLING_STRIDE(2), .DATA_WIDTH(8), .SIGNED_DATA(0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .pool_start(b_pool_start), .pool_mode(b_pool_mode),
        .busy(b_busy), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .out_feature(b_out_feature), .out_row(b_out_row), .out_col(b_out_col), .done(b_done)
    );

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0;
    int    frame[$];
    exp_t  exp_q[$];
    exp_t  e;
    int    done_cnt = 0, done_cyc = 0;
    bit    bp_en = 1'b0;
    time   stall_until = 0;
    bit    held = 1'b0;
    logic [31:0] held_bits;
    int    b_exp[4];
    int    b_idx = 0, b_done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference model: walk every tile of every feature in output order
    task automatic build_expected(input bit mode);
        exp_q.delete();
        for (int f = 0; f < NF; f++)
            for (int tr = 0; tr < PH; tr++)
                for (int tc = 0; tc < PW; tc++) begin
                    int acc = 0, n = 0;
                    for (int r = tr * S; r < tr * S + S && r < H; r++)
                        for (int c = tc * S; c < tc * S + S && c < W; c++) begin
                            int v = frame[f * H * W + r * W + c];
                            if (n == 0) acc = v;
                            else if (mode) acc += v;
                            else if (v > acc) acc = v;
                            n++;
                        end
                    if (mode) acc = acc / n;
                    exp_q.push_back('{acc & 255, f, tr, tc});
                end
    endtask

    always @(posedge clock) cyc++;

    // Consumer: random or stalled backpressure
    always @(posedge clock) begin
        #1;
        if ($time < stall_until) out_ready = 1'b0;
        else if (bp_en)          out_ready = ($urandom % 3) != 0;
        else                     out_ready = 1'b1;
    end

    // Output monitor for the main instance
    always @(negedge clock) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_data, 3'(out_feature), 2'(out_row), 2'(out_col)}, held_bits);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_output", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_feature", out_feature, e.f);
                    check("out_row", out_row, e.r);
                    check("out_col", out_col, e.c);
                end
            end
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
            held      = out_valid && !out_ready;
            held_bits = {out_data, 3'(out_feature), 2'(out_row), 2'(out_col)};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Output monitor for the known-answer instance (always ready)
    always @(negedge clock) begin
        if (reset_n) begin
            if (b_out_valid) begin
                if (b_idx < 4) begin
                    check("b_out_data", b_out_data, b_exp[b_idx]);
                    check("b_out_row", b_out_row, b_idx / 2);
                    check("b_out_col", b_out_col, b_idx % 2);
                end else check("b_extra_output", 1, 0);
                b_idx++;
            end
            if (b_done) b_done_cnt++;
        end
    end

    // 4x4 frame of values 0..15; pool_mode toggles every element
    task automatic run_small(input bit mode);
        int i = 0, guard = 0;
        bit acc;
        if (mode) b_exp = '{2, 4, 10, 12};
        else      b_exp = '{5, 7, 13, 15};
        b_idx = 0;
        b_done_cnt = 0;
        @(posedge clock); #1 b_pool_start = 1'b1; b_pool_mode = mode;
        @(posedge clock); #1 b_pool_start = 1'b0;
        while (i < 16 && guard < 100) begin
            b_in_valid  = 1'b1;
            b_in_data   = 8'(i);
            b_pool_mode = ~b_pool_mode;
            @(negedge clock); acc = b_in_ready;
            @(posedge clock); #1;
            if (acc) i++;
            guard++;
        end
        b_in_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("b_output_count", b_idx, 4);
        check("b_done_count", b_done_cnt, 1);
        check("b_busy_idle", b_busy, 0);
    endtask

    // kind: 0 random signed, 1 all nines, 2 all negative
    task automatic run_frame(input bit mode, input int kind, input bit gaps,
                             input int stall_at, input int abort_at);
        int i = 0, guard = 0, start_cyc;
        bit acc;
        frame.delete();
        for (int k = 0; k < N; k++) begin
            if (kind == 1)      frame.push_back(9);
            else if (kind == 2) frame.push_back(-int'($urandom_range(1, 128)));
            else                frame.push_back(int'($urandom_range(0, 255)) - 128);
        end
        build_expected(mode);
        done_cnt = 0;
        @(posedge clock); #1 pool_start = 1'b1; pool_mode = mode;
        @(negedge clock); start_cyc = cyc;
        @(posedge clock); #1 pool_start = 1'b0;
        while (i < N && guard < 5000) begin
            if (i == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_coords", {out_feature, out_row, out_col}, 0);
                check("rst_done", done, 0);
                in_valid = 1'b0;
                exp_q.delete();
                @(negedge clock); reset_n = 1'b1;
                repeat (6) @(negedge clock);
                check("abort_no_done", done_cnt, 0);
                return;
            end
            in_valid  = gaps ? (($urandom % 4) != 0) : 1'b1;
            in_data   = 8'(frame[i]);
            if (($urandom % 5) == 0) pool_mode = ~pool_mode;
            if (i == stall_at) stall_until = $time + 100;
            @(negedge clock);
            if (i == 0 && guard == 0) begin
                check("busy_rise", busy, 1);
                check("in_ready_rise", in_ready, 1);
            end
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (i < N) check("input_timeout", i, N);
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        else begin
            if (!gaps && !bp_en && stall_at < 0)
                check("frame_cycles", done_cyc - start_cyc, N + 2);
            check("busy_with_done", busy, 0);
        end
        repeat (4) @(negedge clock);
        check("done_count", done_cnt, 1);
        check("outputs_left", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_coords", {out_feature, out_row, out_col}, 0);
        check("reset_done", done, 0);
        @(negedge clock); reset_n = 1'b1;

        run_small(1'b0);
        run_small(1'b1);

        bp_en = 1'b0;
        run_frame(1'b0, 0, 1'b0, -1, -1);
        run_frame(1'b1, 1, 1'b0, -1, -1);
        run_frame(1'b0, 2, 1'b0, -1, -1);
        run_frame(1'b1, 0, 1'b0, -1, -1);

        bp_en = 1'b1;
        run_frame(1'b1, 0, 1'b1, 20, -1);
        run_frame(1'b0, 0, 1'b1, 33, -1);

        bp_en = 1'b0;
        run_frame(1'b0, 0, 1'b0, -1, 17);
        run_frame(1'b1, 0, 1'b1, 8, -1);

        bp_en = 1'b1;
        for (int k = 0; k < 4; k++)
            run_frame(1'($urandom % 2), 0, 1'b1, int'($urandom_range(0, N - 1)), -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
